// File: rtl/fft_bitrev_in.sv
// Ping-pong reorder buffer: captures natural-order blocks and replays them in
// bit-reversed order, one bank filling while the other drains.
module fft_bitrev_in #(
    parameter int LOG2N = 8,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] realin,
    input  logic [DW-1:0] imagin,
    input  logic          startin,
    output logic [DW-1:0] realout,
    output logic [DW-1:0] imagout,
    output logic          startout
);
    localparam int               DEPTH     = 2 ** (LOG2N + 1);
    localparam logic [LOG2N-1:0] ADDR_ZERO = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] ADDR_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] ADDR_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};

    typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [2*DW-1:0]  r_mem [0:DEPTH-1];
    wstate_t          r_wstate;
    rstate_t          r_rstate;
    logic             r_wbank;
    logic             r_rbank;
    logic [LOG2N-1:0] r_wcnt;
    logic [LOG2N-1:0] r_rcnt;
    logic [1:0]       r_full;

    logic             w_we;
    logic [LOG2N-1:0] w_waddr;
    logic             w_wdone;
    logic             w_rdone;
    logic [1:0]       w_set;
    logic [1:0]       w_clr;
    logic             w_next_ready;
    logic [2*DW-1:0]  w_rword;

    // Write-side decode, bank full/empty events and read-word fetch.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = ADDR_ZERO;
        w_wdone = 1'b0;
        if (startin) begin
            // a block arriving while its bank still awaits draining is dropped
            w_we    = ~r_full[r_wbank];
            w_waddr = ADDR_ZERO;
        end else if (r_wstate == W_FILL) begin
            w_we    = 1'b1;
            w_waddr = r_wcnt;
            w_wdone = (r_wcnt == ADDR_LAST);
        end else begin
            w_we    = 1'b0;
            w_waddr = ADDR_ZERO;
        end
        w_rdone      = (r_rstate == R_DRAIN) && (r_rcnt == ADDR_LAST);
        w_set        = w_wdone ? (2'b01 << r_wbank) : 2'b00;
        w_clr        = w_rdone ? (2'b01 << r_rbank) : 2'b00;
        // the other bank may be completing on this very edge
        w_next_ready = r_full[~r_rbank] | (w_wdone & (r_wbank != r_rbank));
        w_rword      = r_mem[{r_rbank, bitrev(r_rcnt)}];
    end

    // Sample storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            r_mem[{r_wbank, w_waddr}] <= {realin, imagin};
        end
    end

    // Write FSM: fills the current write bank, restarting on any startin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_wbank  <= 1'b0;
            r_wcnt   <= ADDR_ZERO;
        end else if (startin) begin
            if (!r_full[r_wbank]) begin
                r_wstate <= W_FILL;
                r_wcnt   <= ADDR_ONE;
            end else begin
                r_wstate <= W_IDLE;
                r_wcnt   <= ADDR_ZERO;
            end
        end else begin
            case (r_wstate)
                W_FILL: begin
                    if (r_wcnt == ADDR_LAST) begin
                        r_wstate <= W_IDLE;
                        r_wcnt   <= ADDR_ZERO;
                        r_wbank  <= ~r_wbank;
                    end else begin
                        r_wcnt   <= r_wcnt + ADDR_ONE;
                    end
                end
                W_IDLE: begin
                    r_wcnt <= ADDR_ZERO;
                end
                default: begin
                    r_wstate <= W_IDLE;
                    r_wcnt   <= ADDR_ZERO;
                end
            endcase
        end
    end

    // Bank occupancy flags; set and clear never target the same bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
        end
    end

    // Read FSM: drains a full bank in bit-reversed order with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_rbank  <= 1'b0;
            r_rcnt   <= ADDR_ZERO;
            realout  <= {DW{1'b0}};
            imagout  <= {DW{1'b0}};
            startout <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_full[r_rbank]) begin
                        r_rstate <= R_DRAIN;
                        r_rcnt   <= ADDR_ONE;
                        realout  <= w_rword[2*DW-1:DW];
                        imagout  <= w_rword[DW-1:0];
                        startout <= 1'b1;
                    end else begin
                        r_rcnt   <= ADDR_ZERO;
                        realout  <= {DW{1'b0}};
                        imagout  <= {DW{1'b0}};
                        startout <= 1'b0;
                    end
                end
                R_DRAIN: begin
                    realout  <= w_rword[2*DW-1:DW];
                    imagout  <= w_rword[DW-1:0];
                    startout <= (r_rcnt == ADDR_ZERO);
                    r_rcnt   <= r_rcnt + ADDR_ONE;
                    if (r_rcnt == ADDR_LAST) begin
                        r_rbank  <= ~r_rbank;
                        r_rstate <= w_next_ready ? R_DRAIN : R_IDLE;
                    end else begin
                        r_rstate <= R_DRAIN;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                    r_rcnt   <= ADDR_ZERO;
                    realout  <= {DW{1'b0}};
                    imagout  <= {DW{1'b0}};
                    startout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bitrev_in.sv
// Directed bench for fft_bitrev_in: ramp, back-to-back, restart, reset, idle, boundary.
module tb_fft_bitrev_in;
    localparam int LOG2N = 8;
    localparam int DW    = 20;
    localparam int N     = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          startin;
    logic [DW-1:0] realin;
    logic [DW-1:0] imagin;
    logic [DW-1:0] realout;
    logic [DW-1:0] imagout;
    logic          startout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_bitrev_in #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .realin   (realin),
        .imagin   (imagin),
        .startin  (startin),
        .realout  (realout),
        .imagout  (imagout),
        .startout (startout)
    );

    function automatic logic [7:0] rev8(input logic [7:0] a);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = a[7-i];
        return r;
    endfunction

    // Apply inputs, then advance past the next rising edge.
    task automatic step(input logic s, input logic [DW-1:0] re, input logic [DW-1:0] im);
        startin = s;
        realin  = re;
        imagin  = im;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 20'h12345, 20'h54321);
        step(1'b0, 20'h0, 20'h0);
        checks++;
        if (realout !== 20'h0 || imagout !== 20'h0 || startout !== 1'b0) begin
            errors++;
            $display("FAIL reset got re=%h im=%h so=%b exp 0 0 0", realout, imagout, startout);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int t = 0; t < 2000; t++) begin
            step(1'b0, DW'(t * 7), DW'(t * 3));
            checks++;
            if (realout !== 20'h0 || imagout !== 20'h0 || startout !== 1'b0) begin
                errors++;
                $display("FAIL idle t=%0d got re=%h im=%h so=%b exp 0 0 0", t, realout, imagout, startout);
            end
        end
    endtask

    task automatic test_ramp();
        logic [7:0]    first8 [8];
        logic [DW-1:0] er, ei;
        logic          es;
        first8 = '{8'd0, 8'd128, 8'd64, 8'd192, 8'd32, 8'd160, 8'd96, 8'd224};
        for (int t = 0; t < 2 * N + 2; t++) begin
            if (t < N) step(t == 0, DW'(t), -DW'(t));
            else       step(1'b0, 20'h0, 20'h0);
            if (t >= N && t < 2 * N) begin
                er = DW'(rev8(8'(t - N)));
                ei = -er;
                es = (t == N);
            end else begin
                er = 20'h0; ei = 20'h0; es = 1'b0;
            end
            checks++;
            if (realout !== er || imagout !== ei || startout !== es) begin
                errors++;
                $display("FAIL ramp t=%0d got re=%h im=%h so=%b exp re=%h im=%h so=%b",
                         t, realout, imagout, startout, er, ei, es);
            end
            if (t >= N && t < N + 8) begin
                checks++;
                if (realout !== DW'(first8[t-N])) begin
                    errors++;
                    $display("FAIL ramp_head j=%0d got %h exp %h", t - N, realout, first8[t-N]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] er;
        logic          es;
        int            j, b;
        for (int t = 0; t < 4 * N + 2; t++) begin
            if (t < 3 * N) step((t % N) == 0, DW'((t / N) * 4096 + (t % N)), -DW'((t / N) * 4096 + (t % N)));
            else           step(1'b0, 20'h0, 20'h0);
            if (t >= N && t < 4 * N) begin
                j  = (t - N) % N;
                b  = (t - N) / N;
                er = DW'(b * 4096 + int'(rev8(8'(j))));
                es = (j == 0);
            end else begin
                er = 20'h0; es = 1'b0;
            end
            checks++;
            if (realout !== er || imagout !== -er || startout !== es) begin
                errors++;
                $display("FAIL b2b t=%0d got re=%h im=%h so=%b exp re=%h so=%b",
                         t, realout, imagout, startout, er, es);
            end
            if (t == 2 * N + 1) begin
                checks++;
                if (realout !== 20'h01080) begin
                    errors++;
                    $display("FAIL b2b_blk1_j1 got %h exp 01080", realout);
                end
            end
        end
    endtask

    task automatic test_restart();
        logic [DW-1:0] er;
        logic          es;
        int            starts = 0;
        for (int t = 0; t < 356 + N + 4; t++) begin
            if (t < 100)      step(t == 0, DW'(32'h0A000 + t), 20'h0);
            else if (t < 356) step(t == 100, DW'(32'h05000 + t - 100), 20'h0);
            else              step(1'b0, 20'h0, 20'h0);
            if (startout === 1'b1) starts++;
            if (t >= 356 && t < 356 + N) begin
                er = DW'(32'h05000 + int'(rev8(8'(t - 356))));
                es = (t == 356);
            end else begin
                er = 20'h0; es = 1'b0;
            end
            checks++;
            if (realout !== er || imagout !== 20'h0 || startout !== es) begin
                errors++;
                $display("FAIL restart t=%0d got re=%h im=%h so=%b exp re=%h so=%b",
                         t, realout, imagout, startout, er, es);
            end
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL restart_count got %0d blocks exp 1", starts);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int t = 0; t <= N + 50; t++) begin
            if (t < N) step(t == 0, DW'(32'h03000 + t), -DW'(32'h03000 + t));
            else       step(1'b0, 20'h0, 20'h0);
        end
        checks++;
        if (realout !== 20'h0304C || imagout !== -20'h0304C) begin
            errors++;
            $display("FAIL mid_j50 got re=%h im=%h exp re=0304c", realout, imagout);
        end
        reset = 1'b1;
        step(1'b0, 20'h0, 20'h0);
        reset = 1'b0;
        checks++;
        if (realout !== 20'h0 || imagout !== 20'h0 || startout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got re=%h im=%h so=%b exp 0 0 0", realout, imagout, startout);
        end
        for (int t = 0; t < 600; t++) begin
            step(1'b0, DW'(t), DW'(t));
            checks++;
            if (realout !== 20'h0 || imagout !== 20'h0 || startout !== 1'b0) begin
                errors++;
                $display("FAIL post_reset t=%0d got re=%h im=%h so=%b exp 0 0 0", t, realout, imagout, startout);
            end
        end
    endtask

    task automatic test_boundary();
        logic [DW-1:0] re, im;
        for (int t = 0; t < 2 * N + 1; t++) begin
            re = DW'(t); im = 20'h0;
            if (t == 1)   begin re = 20'h7FFFF; im = 20'h80000; end
            if (t == 254) begin re = 20'h80000; im = 20'h7FFFF; end
            if (t < N) step(t == 0, re, im);
            else       step(1'b0, 20'h0, 20'h0);
            if (t == N) begin
                checks++;
                if (startout !== 1'b1) begin
                    errors++;
                    $display("FAIL bnd_start got so=%b exp 1", startout);
                end
            end
            if (t == N + 127) begin
                checks++;
                if (realout !== 20'h80000 || imagout !== 20'h7FFFF) begin
                    errors++;
                    $display("FAIL bnd_j127 got re=%h im=%h exp 80000 7ffff", realout, imagout);
                end
            end
            if (t == N + 128) begin
                checks++;
                if (realout !== 20'h7FFFF || imagout !== 20'h80000) begin
                    errors++;
                    $display("FAIL bnd_j128 got re=%h im=%h exp 7ffff 80000", realout, imagout);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        startin = 1'b0;
        realin  = 20'h0;
        imagin  = 20'h0;
        test_reset();
        test_idle();
        test_ramp();
        test_back_to_back();
        test_restart();
        test_reset_mid_drain();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
